ram_simple: RTL and testbench

Single-port synchronous RAM, DATA_WIDTH × 2^ADDR_WIDTH words, with one shared address bus, write enable and registered read data. It serves as the generic on-chip scratch memory for datapath blocks. A synchronous reset starts a hardware clear sweep that zeroes every word, so contents are deterministic after reset.

---
 rtl/ram_simple.sv | 29 ++
 tb/tb_ram_simple.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ram_simple.sv
// ram_simple: single-port synchronous RAM with registered read and post-reset clear sweep
module ram_simple #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ptr;
  always_ff @(posedge clk)
    if (!rst && (busy || we)) mem[busy ? ptr : addr] <= busy ? '0 : data_in;
  always_ff @(posedge clk)
    if (rst) begin
      data_out <= '0;
      busy     <= 1'b1;
      ptr      <= '0;
    end else if (busy) begin
      data_out <= '0;
      ptr      <= ptr + 1'b1;
      busy     <= ~&ptr;
    end else data_out <= we ? data_in : mem[addr];
endmodule

// File: tb/tb_ram_simple.sv
// tb_ram_simple: randomized and directed checks of ram_simple against a behavioural memory model
module tb_ram_simple;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       busy;
  int checks = 0;
  int errors = 0;

  ram_simple dut (.clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in),
                  .data_out(data_out), .busy(busy));

  always #5 clk = ~clk;

  logic [7:0] m_mem [256];
  logic [7:0] m_dout;
  bit         m_busy;
  bit         m_valid = 1'b0;
  int         m_left;

  initial for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);

  // Model: a reset schedules 256 clearing edges; afterwards plain array read/write-first
  always @(posedge clk) begin
    if (rst) begin
      m_dout = 8'h00; m_busy = 1'b1; m_left = 256; m_valid = 1'b1;
    end else if (m_valid && m_busy) begin
      m_mem[256 - m_left] = 8'h00;
      m_left = m_left - 1;
      m_busy = (m_left > 0);
      m_dout = 8'h00;
    end else if (m_valid) begin
      if (we) m_mem[addr] = data_in;
      m_dout = m_mem[addr];
    end
  end

  always @(negedge clk) if (m_valid) begin
    checks++;
    if (data_out !== m_dout || busy !== m_busy) begin
      errors++;
      $display("FAIL model t=%0t data_out=%h busy=%b expected data_out=%h busy=%b",
               $time, data_out, busy, m_dout, m_busy);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
    we = w; addr = a; data_in = d;
    @(negedge clk);
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;

  initial begin
    @(negedge clk); @(negedge clk);
    chk("reset_busy", {7'b0, busy}, 8'h01);
    chk("reset_dout", data_out, 8'h00);
    we = 1'b1; addr = 8'h10; data_in = 8'hFF;
    rst = 1'b0;
    wait_sweep(n);
    chk("sweep_len", 8'(n), 8'(256));
    chk("sweep_len_hi", 8'(n >> 8), 8'h01);
    access(0, 8'h00, 8'h00); chk("clr_00", data_out, 8'h00);
    access(0, 8'h03, 8'h00); chk("clr_03", data_out, 8'h00);
    access(0, 8'hFF, 8'h00); chk("clr_ff", data_out, 8'h00);
    access(0, 8'h10, 8'h00); chk("sweep_write_ignored", data_out, 8'h00);
    access(1, 8'h03, 8'h12); chk("write_through", data_out, 8'h12);
    access(0, 8'h03, 8'h00); chk("read_03", data_out, 8'h12);
    access(0, 8'h03, 8'h00); chk("hold_03", data_out, 8'h12);
    access(1, 8'h00, 8'hA5);
    access(1, 8'hFF, 8'h5A);
    access(0, 8'h00, 8'h00); chk("read_00", data_out, 8'hA5);
    access(0, 8'hFF, 8'h00); chk("read_ff", data_out, 8'h5A);
    access(0, 8'h01, 8'h00); chk("read_01", data_out, 8'h00);
    access(1, 8'h40, 8'h11);
    access(1, 8'h40, 8'h22);
    access(0, 8'h40, 8'h00); chk("overwrite", data_out, 8'h22);
    for (int i = 0; i < 400; i++)
      access(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
             8'($urandom));
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
    chk("mid_sweep_busy", {7'b0, busy}, 8'h01);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    wait_sweep(n);
    chk("restart_len", 8'(n), 8'(256));
    chk("restart_len_hi", 8'(n >> 8), 8'h01);
    access(1, 8'h20, 8'h33);
    chk("pre_reset_write", data_out, 8'h33);
    rst = 1'b1; we = 1'b1; addr = 8'h20; data_in = 8'h77;
    @(negedge clk);
    chk("abort_dout", data_out, 8'h00);
    chk("abort_busy", {7'b0, busy}, 8'h01);
    rst = 1'b0; we = 1'b0;
    wait_sweep(n);
    chk("abort_len", 8'(n), 8'(256));
    access(0, 8'h20, 8'h00); chk("abort_no_write", data_out, 8'h00);
    for (int i = 0; i < 200; i++)
      access(1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
